// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants and counter-width helper.
// The optional frame limit is enabled by defining VGA_SYNC_GEN_FRAME_LIMIT_EN.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam bit          DEF_SYNC_POL    = 1'b0;
    localparam int unsigned DEF_FRAME_LIMIT = 1000;
    localparam int unsigned DEF_FCW         = 16;

    // Position counter width for an axis of the given total length (never below 1 bit).
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-enable input and raster timing outputs of vga_sync_gen, grouped as one bus.
interface vga_sync_gen_if #(
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 10,
    parameter int unsigned FCW = 16
);
    logic           CE;
    logic           HSYNC;
    logic           VSYNC;
    logic           ACTIVE;
    logic [XW-1:0]  X;
    logic [YW-1:0]  Y;
    logic           LINE_START;
    logic           FRAME_START;
    logic [FCW-1:0] FRAME_CNT;
    logic           DONE;

    modport master (
        output CE,
        input  HSYNC, VSYNC, ACTIVE, X, Y, LINE_START, FRAME_START, FRAME_CNT, DONE
    );

    modport slave (
        input  CE,
        output HSYNC, VSYNC, ACTIVE, X, Y, LINE_START, FRAME_START, FRAME_CNT, DONE
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, next-position decode and registered sync.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned FP       = DEF_H_FP,
    parameter int unsigned SYNC     = DEF_H_SYNC,
    parameter int unsigned BP       = DEF_H_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL,
    localparam int unsigned TOTAL   = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int unsigned W       = cnt_width(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic         last_o,
    output logic [W-1:0] nxt_pos_o,
    output logic         nxt_active_o,
    output logic         sync_o
);
    localparam logic [W-1:0] LAST_POS = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO  = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI  = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] pos_q, pos_d;
    logic         sync_q, sync_d;

    always_comb begin
        pos_d = pos_q;
        if (en_i) begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
        end
        // Sync is a decode of the position the counter is about to hold.
        sync_d = ((pos_d >= SYNC_LO) && (pos_d < SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q  <= LAST_POS;
            sync_q <= ~SYNC_POL;
        end else begin
            pos_q  <= pos_d;
            sync_q <= sync_d;
        end
    end

    assign last_o       = (pos_q == LAST_POS);
    assign nxt_pos_o    = pos_d;
    assign nxt_active_o = (pos_d < ACT_END);
    assign sync_o       = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters, syncs, active video, strobes and frame count.
// Optional stop-after-FRAME_LIMIT behaviour is enabled by VGA_SYNC_GEN_FRAME_LIMIT_EN.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          SYNC_POL    = DEF_SYNC_POL,
    parameter int unsigned FRAME_LIMIT = DEF_FRAME_LIMIT,
    parameter int unsigned FCW         = DEF_FCW
) (
    input logic           CLK_IN,
    input logic           RST,
    vga_sync_gen_if.slave bus
);
    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned XW      = cnt_width(H_TOTAL);
    localparam int unsigned YW      = cnt_width(V_TOTAL);

    localparam logic [FCW-1:0] LIMIT_CNT = FCW'(FRAME_LIMIT);

    logic          h_last, v_last;
    logic [XW-1:0] h_nxt;
    logic [YW-1:0] v_nxt;
    logic          h_nxt_act, v_nxt_act;
    logic          h_sync, v_sync;
    logic          frame_wrap;
    logic          run, stop;

    logic           primed_q, primed_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           act_q, act_d;
    logic           ls_q, ls_d;
    logic           fs_q, fs_d;

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h (
        .clk_i        (CLK_IN),
        .rst_i        (RST),
        .en_i         (run),
        .last_o       (h_last),
        .nxt_pos_o    (h_nxt),
        .nxt_active_o (h_nxt_act),
        .sync_o       (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v (
        .clk_i        (CLK_IN),
        .rst_i        (RST),
        .en_i         (run & h_last),
        .last_o       (v_last),
        .nxt_pos_o    (v_nxt),
        .nxt_active_o (v_nxt_act),
        .sync_o       (v_sync)
    );

    assign frame_wrap = h_last & v_last;

`ifdef VGA_SYNC_GEN_FRAME_LIMIT_EN
    localparam logic [FCW-1:0] LIMIT_PREV = FCW'(FRAME_LIMIT - 1);

    logic done_q;

    // The wrap that would complete frame FRAME_LIMIT is swallowed: counters hold at the
    // last blanking pixel, so every registered output stays blanked with syncs idle.
    always_comb begin
        stop = bus.CE & ~done_q & primed_q & frame_wrap & (cnt_q == LIMIT_PREV);
        run  = bus.CE & ~done_q & ~stop;
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            done_q <= 1'b0;
        end else if (stop) begin
            done_q <= 1'b1;
        end
    end

    assign bus.DONE = done_q;
`else
    always_comb begin
        stop = 1'b0;
        run  = bus.CE;
    end

    assign bus.DONE = 1'b0;
`endif

    always_comb begin
        primed_d = primed_q | run;

        cnt_d = cnt_q;
        if (stop) begin
            cnt_d = LIMIT_CNT;
        end else if (run && frame_wrap && primed_q) begin
            cnt_d = cnt_q + 1'b1;
        end

        act_d = h_nxt_act & v_nxt_act;
        x_d   = act_d ? h_nxt : '0;
        y_d   = act_d ? v_nxt : '0;
        ls_d  = run & h_last;
        fs_d  = run & frame_wrap;
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            primed_q <= 1'b0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            act_q    <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            act_q    <= act_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign bus.HSYNC       = h_sync;
    assign bus.VSYNC       = v_sync;
    assign bus.ACTIVE      = act_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.LINE_START  = ls_q;
    assign bus.FRAME_START = fs_q;
    assign bus.FRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 instance plus a tiny-timing instance.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int unsigned total_cnt = 0;
    int unsigned bad_cnt   = 0;

    vga_sync_gen_if #(.XW(10), .YW(10), .FCW(16)) b0 ();
    vga_sync_gen_if #(.XW(3),  .YW(3),  .FCW(2))  b1 ();

    vga_sync_gen #(.FCW(16)) dut0 (
        .CLK_IN (clk),
        .RST    (rst0),
        .bus    (b0)
    );

    vga_sync_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .FRAME_LIMIT (3), .FCW (2)
    ) dut1 (
        .CLK_IN (clk),
        .RST    (rst1),
        .bus    (b1)
    );

    typedef struct {
        int unsigned x, y;
        bit          act, hs, vs, ls, fs;
        int unsigned cnt;
        bit          done;
    } exp_t;

    typedef struct {
        int unsigned ha, hf, hsy, hb, va, vf, vsy, vb, cntmod, limit;
    } cfg_t;

    typedef struct {
        bit          ce;
        int unsigned x, y;
        bit          act, hs, vs, ls, fs;
        int unsigned cnt;
    } vec_t;

    // Expected outputs after n advancing CEs since reset (arithmetic, not counter based).
    function automatic exp_t model(input cfg_t c, input int unsigned n, input bit ce_prev);
        exp_t e;
        int unsigned ht, vt, p, h, v;
        ht = c.ha + c.hf + c.hsy + c.hb;
        vt = c.va + c.vf + c.vsy + c.vb;
        e = '{default: 0};
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (n == 0) return e;
        if (c.limit != 0 && n >= 1 + c.limit * ht * vt) begin
            e.cnt  = c.limit;
            e.done = 1'b1;
            return e;
        end
        p = n - 1;
        h = p % ht;
        v = (p / ht) % vt;
        e.act = (h < c.ha) && (v < c.va);
        e.x   = e.act ? h : 0;
        e.y   = e.act ? v : 0;
        e.hs  = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hsy));
        e.vs  = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vsy));
        e.ls  = ce_prev && (h == 0);
        e.fs  = ce_prev && (h == 0) && (v == 0);
        e.cnt = (p / (ht * vt)) % c.cntmod;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total_cnt++;
        if (a !== e) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic check0(input string tag, input exp_t e);
        chk({tag, ".X"},    32'(b0.X),           e.x);
        chk({tag, ".Y"},    32'(b0.Y),           e.y);
        chk({tag, ".ACT"},  32'(b0.ACTIVE),      32'(e.act));
        chk({tag, ".HS"},   32'(b0.HSYNC),       32'(e.hs));
        chk({tag, ".VS"},   32'(b0.VSYNC),       32'(e.vs));
        chk({tag, ".LS"},   32'(b0.LINE_START),  32'(e.ls));
        chk({tag, ".FS"},   32'(b0.FRAME_START), 32'(e.fs));
        chk({tag, ".CNT"},  32'(b0.FRAME_CNT),   e.cnt);
        chk({tag, ".DONE"}, 32'(b0.DONE),        32'(e.done));
    endtask

    task automatic check1(input string tag, input exp_t e);
        chk({tag, ".X"},    32'(b1.X),           e.x);
        chk({tag, ".Y"},    32'(b1.Y),           e.y);
        chk({tag, ".ACT"},  32'(b1.ACTIVE),      32'(e.act));
        chk({tag, ".HS"},   32'(b1.HSYNC),       32'(e.hs));
        chk({tag, ".VS"},   32'(b1.VSYNC),       32'(e.vs));
        chk({tag, ".LS"},   32'(b1.LINE_START),  32'(e.ls));
        chk({tag, ".FS"},   32'(b1.FRAME_START), 32'(e.fs));
        chk({tag, ".CNT"},  32'(b1.FRAME_CNT),   e.cnt);
        chk({tag, ".DONE"}, 32'(b1.DONE),        32'(e.done));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_t        c0, c1;
        vec_t        tbl[11];
        exp_t        e;
        int unsigned n;
        bit          cep;

        c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 65536, 0};
        c1 = '{4, 1, 1, 1, 2, 1, 1, 1, 4, 0};
`ifdef VGA_SYNC_GEN_FRAME_LIMIT_EN
        c0.limit = 1000;
        c1.limit = 3;
`endif
        //            ce x  y  a  hs vs ls fs cnt
        tbl[0]  = '{1, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 2, 0, 1, 1, 1, 0, 0, 0};
        tbl[4]  = '{1, 3, 0, 1, 1, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
        tbl[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};

        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.CE = 1'b0;
        b1.CE = 1'b0;
        #12;
        check0("rst0", model(c0, 0, 0));
        check1("rst1", model(c1, 0, 0));
        tick;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Small instance: table of single-clock vectors, CE=0 entries must hold.
        for (int i = 0; i < 11; i++) begin
            b1.CE = tbl[i].ce;
            tick;
            e = '{tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].hs, tbl[i].vs,
                  tbl[i].ls, tbl[i].fs, tbl[i].cnt, 1'b0};
            check1($sformatf("vec%0d", i), e);
        end

        // Small instance: free run through several frames (wrap, or limit stop and freeze).
        n = 9;
        b1.CE = 1'b1;
        while (n < 150) begin
            tick;
            n++;
            check1($sformatf("run1.n%0d", n), model(c1, n, 1'b1));
        end

        // Small instance: async reset mid-line, counter restarts from zero.
        #2 rst1 = 1'b1;
        #1 check1("arst1", model(c1, 0, 0));
        tick;
        check1("arst1.hold", model(c1, 0, 0));
        #2 rst1 = 1'b0;
        n = 0;
        while (n < 40) begin
            tick;
            n++;
            check1($sformatf("rec1.n%0d", n), model(c1, n, 1'b1));
        end
        b1.CE = 1'b0;

        // Default instance: CE tied high for three lines plus 300 pixels.
        n = 0;
        b0.CE = 1'b1;
        while (n < 2701) begin
            tick;
            n++;
            check0($sformatf("run0.n%0d", n), model(c0, n, 1'b1));
        end
        chk("x300", 32'(b0.X), 300);

        // Async reset at X=300: outputs return before the next clock edge.
        #2 rst0 = 1'b1;
        #1 check0("arst0", model(c0, 0, 0));
        #2 rst0 = 1'b0;

        // Default instance: CE on every 4th clock, strobes must stay one clock wide.
        n = 0;
        for (int k = 0; k < 3600; k++) begin
            cep = (k % 4 == 0);
            b0.CE = cep;
            tick;
            if (cep) n++;
            check0($sformatf("ce4.k%0d", k), model(c0, n, cep));
        end
        b0.CE = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA raster timing generator: horizontal/vertical position counters advanced by a pixel clock-enable, producing sync pulses, an active-video flag, pixel coordinates, line/frame strobes and a completed-frame counter with an optional stop-after-N-frames limit. Sits between the board clock and the pixel/colour logic driving R/G/B. Replaces ad-hoc free-running cycle counters with terminal-count stop behaviour.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- FRAME_LIMIT, 1000, completed frames before stop (used only with limit macro)
- FCW, 16, FRAME_CNT width
- CLK_IN  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CE  in  1  pixel enable; counters advance only on cycles with CE=1
- HSYNC  out  1  horizontal sync, SYNC_POL when asserted
- VSYNC  out  1  vertical sync, SYNC_POL when asserted
- ACTIVE  out  1  high while position is inside visible area
- X  out  $clog2(H_TOTAL)  horizontal position when ACTIVE, else 0
- Y  out  $clog2(V_TOTAL)  vertical position when ACTIVE, else 0
- LINE_START  out  1  one-cycle pulse when h wraps to 0
- FRAME_START  out  1  one-cycle pulse when (h,v) wraps to (0,0)
- FRAME_CNT  out  FCW  completed frames since reset
- DONE  out  1  frame limit reached (sticky)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. All eight timing parameters ≥1.
- Horizontal layout: active [0,H_ACTIVE), FP, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), BP. Vertical identical in lines.
- On CE: h increments; at H_TOTAL-1 wraps to 0 and v increments; v wraps at V_TOTAL-1 to 0. CE=0: everything holds, strobes 0.
- Reset: h=H_TOTAL-1, v=V_TOTAL-1 (last blanking pixel), primed=0. Outputs: HSYNC=VSYNC=~SYNC_POL, ACTIVE=0, X=Y=0, strobes 0, FRAME_CNT=0, DONE=0.
- First CE after reset: wrap to (0,0), FRAME_START=LINE_START=1, primed←1, FRAME_CNT unchanged.
- Every later wrap to (0,0) increments FRAME_CNT (mod 2^FCW when limit disabled).
- ACTIVE = h<H_ACTIVE and v<V_ACTIVE. HSYNC depends on h only, VSYNC on v only (VSYNC spans whole lines).
- Reset asserted mid-frame: immediate asynchronous return to reset state; sequence restarts as above.

## Timing
- All outputs registered. The CE edge that moves the counters to position (h,v) updates every output to the decode of (h,v) on the same edge; zero extra latency between X/Y, ACTIVE and syncs.
- Strobes high exactly one CLK_IN cycle, only after a CE cycle; with CE tied 1, one pixel per clock.
- Line period H_TOTAL CE pulses; frame period H_TOTAL·V_TOTAL CE pulses (default 420000).

## Configuration
- VGA_SYNC_GEN_FRAME_LIMIT_EN defined: the CE that would complete frame number FRAME_LIMIT instead holds position at (H_TOTAL-1,V_TOTAL-1), sets FRAME_CNT=FRAME_LIMIT and DONE=1, no FRAME_START/LINE_START pulse. Thereafter CE ignored, outputs frozen (blanked, syncs deasserted) until RST.
- Not defined: DONE constant 0, free-running, FRAME_LIMIT unused.

## Structure
- Shared package vga_pkg: default 640x480@60 timing constants, SYNC_POL default, helper for counter widths.
- One natural sub-module vga_axis_counter (parametrised ACTIVE/FP/SYNC/BP, count-enable in, wrap/active/sync out), instantiated for horizontal and vertical axes; vertical enabled by horizontal wrap.

## Test plan
- Reset release, CE=1 constant, defaults -> first clock: X=0,Y=0,ACTIVE=1, FRAME_START=1; HSYNC low from pixel 656 to 751 inclusive, LINE_START every 800 clocks.
- Run 2 frames -> VSYNC low for lines 490–491 (1600 clocks); FRAME_CNT=1 after clock 420001, =2 after 840001.
- CE every 4th clock -> all periods stretch ×4, X increments once per 4 clocks, strobes still 1 clock wide.
- Small timings (H 4/1/1/1, V 2/1/1/1), limit macro, FRAME_LIMIT=3 -> after 1+3·35 CE: DONE=1, FRAME_CNT=3, ACTIVE=0, further CE changes nothing.
- Same small config without macro, FCW=2 -> FRAME_CNT wraps 3→0, DONE stays 0.
- RST pulsed mid-line (X=300) -> outputs at reset values asynchronously; next CE gives FRAME_START, FRAME_CNT=0.
